// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the completion-counter width.
package mdu_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator: {hi,lo} for MULT/MULTU and
// {remainder,quotient} for DIV/DIVU, including the divide corner cases.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic        mul_sext;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // One multiplier and one unsigned divider serve both signednesses:
  // signed ops are folded into sign extension / magnitudes around them.
  always_comb begin
    mul_sext = (op_i == MDU_MULT);
    a_ext    = {{32{mul_sext & a_i[31]}}, a_i};
    b_ext    = {{32{mul_sext & b_i[31]}}, b_i};
    prod     = a_ext * b_ext;

    a_neg = (op_i == MDU_DIV) & a_i[31];
    b_neg = (op_i == MDU_DIV) & b_i[31];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    q_mag = (b_mag != '0) ? (a_mag / b_mag) : '1;
    r_mag = (b_mag != '0) ? (a_mag % b_mag) : a_mag;
    // 0x8000_0000 / -1 falls out naturally: magnitude 0x8000_0000 negates to itself.
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    res_o = '0;
    case (op_i)
      MDU_MULT, MDU_MULTU: res_o = prod;
      MDU_DIV, MDU_DIVU: begin
        if (b_i == '0) res_o = {a_i, 32'hFFFF_FFFF};
        else           res_o = {rem, quot};
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// acceptance and held in a pending register until the latency counter expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic [63:0]      arith_res;

  mdu_arith u_arith (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .res_o (arith_res)
  );

  // Handshake: start is sampled on a rising edge and acted on only while
  // busy is low; any start seen while busy is high (including MTHI/MTLO and
  // on the completing edge) is dropped, so the pipeline must hold it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              pend_d  = arith_res;
              cnt_d   = is_div_op(op) ? DIV_LOAD : MUL_LOAD;
              state_d = RUN;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus random mul/div
// traffic scored against a queue of expected {hi,lo} values.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MUL_C = 5;
  localparam int DIV_C = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  int tests_run = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mdu_unit #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int sq, sr, ia, ib;
    model = '0;
    case (o)
      MDU_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        model = sa * sb;
      end
      MDU_MULTU: model = {32'd0, a} * {32'd0, b};
      MDU_DIVU: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else        model = {a % b, a / b};
      end
      MDU_DIV: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          ia = a; ib = b;
          sq = ia / ib;
          sr = ia % ib;
          model = {sr[31:0], sq[31:0]};
        end
      end
      default: model = '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; counts edges since the call and busy-high samples.
  task automatic collect(output bit got, output int cycles, output int busy_cnt);
    got = 1'b0; cycles = 0; busy_cnt = 0;
    while (cycles < 64) begin
      if (busy) busy_cnt++;
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (hi !== 32'd0)  begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
    tests_run++; if (lo !== 32'd0)  begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mult;
    bit got; int cyc, bc; logic [63:0] e;
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || cyc != MUL_C) begin fails++; $display("FAIL mult_latency got=%0d done=%b exp=%0d", cyc, got, MUL_C); end
    tests_run++; if (bc != MUL_C) begin fails++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bc, MUL_C); end
    tests_run++; if ({hi, lo} !== e) begin fails++; $display("FAIL mult_result got=%h exp=%h", {hi, lo}, e); end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_multu;
    bit got; int cyc, bc; logic [63:0] e;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || cyc != MUL_C) begin fails++; $display("FAIL multu_latency got=%0d done=%b exp=%0d", cyc, got, MUL_C); end
    tests_run++; if ({hi, lo} !== e) begin fails++; $display("FAIL multu_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_div;
    bit got; int cyc, bc; logic [63:0] e;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || cyc != DIV_C) begin fails++; $display("FAIL div_latency got=%0d done=%b exp=%0d", cyc, got, DIV_C); end
    tests_run++; if (bc != DIV_C) begin fails++; $display("FAIL div_busy_cycles got=%0d exp=%0d", bc, DIV_C); end
    tests_run++; if ({hi, lo} !== e) begin fails++; $display("FAIL div_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_div_corners;
    bit got; int cyc, bc; logic [63:0] e;
    logic [2:0]  c_op[2] = '{MDU_DIVU, MDU_DIV};
    logic [31:0] c_a[2]  = '{32'd100, 32'h8000_0000};
    logic [31:0] c_b[2]  = '{32'd0, 32'hFFFF_FFFF};
    logic [63:0] c_e[2]  = '{{32'd100, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
    for (int i = 0; i < 2; i++) begin
      issue(c_op[i], c_a[i], c_b[i]);
      exp_q.push_back(c_e[i]);
      collect(got, cyc, bc);
      e = exp_q.pop_front();
      tests_run++; if (!got || {hi, lo} !== e) begin fails++; $display("FAIL div_corner%0d got=%h done=%b exp=%h", i, {hi, lo}, got, e); end
    end
  endtask

  task automatic test_ignored;
    bit got; int cyc, bc; logic [63:0] e;
    issue(MDU_MTHI, 32'h5555_0000, 32'd0);
    tests_run++; if (hi !== 32'h5555_0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mthi_idle got hi=%h busy=%b done=%b exp hi=55550000 busy=0 done=0", hi, busy, done);
    end
    issue(MDU_DIV, 32'd7, 32'd2);
    exp_q.push_back({32'd1, 32'd3});
    issue(MDU_MTHI, 32'h1234_5678, 32'd0);
    tests_run++; if (hi !== 32'h5555_0000) begin fails++; $display("FAIL mthi_busy_hi got=%h exp=55550000", hi); end
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || cyc != DIV_C - 1) begin fails++; $display("FAIL div_after_mthi_latency got=%0d done=%b exp=%0d", cyc, got, DIV_C - 1); end
    tests_run++; if ({hi, lo} !== e) begin fails++; $display("FAIL div_after_mthi_result got=%h exp=%h", {hi, lo}, e); end
    issue(MDU_MTLO, 32'h0000_CAFE, 32'd0);
    tests_run++; if (lo !== 32'h0000_CAFE || hi !== 32'd1) begin fails++; $display("FAIL mtlo got hi=%h lo=%h exp hi=00000001 lo=0000cafe", hi, lo); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mtlo_flags got busy=%b done=%b exp 0 0", busy, done); end
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests_run++; if (hi !== 32'd1 || lo !== 32'h0000_CAFE || busy !== 1'b0) begin
      fails++; $display("FAIL undef_op got hi=%h lo=%h busy=%b exp hi=00000001 lo=0000cafe busy=0", hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back;
    bit got; int cyc, bc; logic [63:0] e;
    issue(MDU_MULT, 32'd1000, 32'hFFFF_FFF6);
    exp_q.push_back(model(MDU_MULT, 32'd1000, 32'hFFFF_FFF6));
    repeat (MUL_C - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; A = 32'h0001_0000; B = 32'h0003_0000;
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_completion got done=%b busy=%b exp 1 0", done, busy); end
    e = exp_q.pop_front();
    tests_run++; if ({hi, lo} !== e) begin fails++; $display("FAIL b2b_first_result got=%h exp=%h", {hi, lo}, e); end
    exp_q.push_back(model(MDU_MULTU, 32'h0001_0000, 32'h0003_0000));
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_second_accept got busy=%b exp 1", busy); end
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || cyc != MUL_C || {hi, lo} !== e) begin
      fails++; $display("FAIL b2b_second got=%h cyc=%0d done=%b exp=%h cyc=%0d", {hi, lo}, cyc, got, e, MUL_C);
    end
  endtask

  task automatic test_reset_mid;
    bit got; int cyc, bc, dcount; logic [63:0] e;
    issue(MDU_MULT, 32'd6, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b exp 0 0 0", hi, lo, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    dcount = 0;
    repeat (MUL_C + 4) begin @(posedge clk); #1; if (done) dcount++; end
    tests_run++; if (dcount != 0 || lo !== 32'd0) begin fails++; $display("FAIL reset_mid_no_done got done_count=%0d lo=%h exp 0 0", dcount, lo); end
    issue(MDU_MULT, 32'd6, 32'd7);
    exp_q.push_back({32'd0, 32'd42});
    collect(got, cyc, bc);
    e = exp_q.pop_front();
    tests_run++; if (!got || {hi, lo} !== e) begin fails++; $display("FAIL reset_mid_rerun got=%h done=%b exp=%h", {hi, lo}, got, e); end
  endtask

  task automatic test_random;
    bit got; int cyc, bc, exp_cyc; logic [63:0] e;
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      exp_cyc = is_div_op(o) ? DIV_C : MUL_C;
      issue(o, a, b);
      exp_q.push_back(model(o, a, b));
      collect(got, cyc, bc);
      e = exp_q.pop_front();
      tests_run++; if (!got || cyc != exp_cyc || {hi, lo} !== e) begin
        fails++; $display("FAIL random%0d op=%0d a=%h b=%h got=%h cyc=%0d exp=%h cyc=%0d", i, o, a, b, {hi, lo}, cyc, e, exp_cyc);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_corners;
    test_ignored;
    test_back_to_back;
    test_reset_mid;
    test_random;
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit. It sits beside the combinational ALU in the EX stage and takes the same 32-bit A/B operands. It owns the HI/LO register pair. Pipeline control uses busy and start to stall later HI/LO-dependent instructions; the ALU itself never stalls.

Parameters:
MUL_CYCLES, 5, cycles from start acceptance to HI/LO update for MULT/MULTU (range 1..31)
DIV_CYCLES, 10, cycles from start acceptance to HI/LO update for DIV/DIVU (range 1..31)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted on a rising edge when busy=0
op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in the package)
A  input  32  operand rs
B  input  32  operand rt
busy  output  1  operation in flight
done  output  1  one-cycle pulse on the cycle HI/LO take the new result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-operation aborts immediately; the pending result is discarded.
- FSM states: IDLE, RUN.
- IDLE + start + op in {MULT, MULTU, DIV, DIVU}:
  - latch A and B;
  - compute the 64-bit result into a pending register;
  - load counter with MUL_CYCLES-1 or DIV_CYCLES-1;
  - go to RUN; busy=1 from the next cycle.
- RUN: the counter decrements each cycle. When counter==0:
  - hi/lo are written with the pending result;
  - done pulses on the same cycle as the write;
  - busy drops that same cycle;
  - the FSM returns to IDLE.
- Latency: with start at edge N, hi/lo are visible after edge N+MUL_CYCLES (or N+DIV_CYCLES). busy is high for exactly MUL_CYCLES (or DIV_CYCLES) cycles.
- MTHI/MTLO in IDLE: hi<=A or lo<=A at the same edge. busy stays 0 and done stays 0.
- start while busy=1: ignored entirely, including MTHI/MTLO. The pipeline must stall such instructions; the bench checks that no state changes.
- Undefined op codes: ignored.
- start in the same cycle as completion: busy is still 1 at that edge, so the request is ignored. The new start is accepted one cycle later.
- Arithmetic:
  - MULT: {hi,lo} = signed(A)*signed(B), 64-bit.
  - MULTU: {hi,lo} = unsigned product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder sign follows the dividend.
- Divide corner cases:
  - Divide by zero: lo=32'hFFFF_FFFF, hi=A. This applies to both DIV and DIVU.
  - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. There is no trap.
- Outputs hi and lo are registered and hold between operations.

Decomposition:
- Shared package (mdu_pkg):
  - op encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - FSM state encoding: IDLE=0, RUN=1.
- One sub-module is natural: mdu_arith, a combinational 64-bit result generator that takes op, A and B and implements the signed/unsigned and divide corner-case rules.
- mdu_unit holds the FSM, the counter, the pending register and hi/lo.

Test Plan:
- Signed multiply: after reset, MULT A=32'hFFFF_FFFE (-2), B=3. Response: busy high 5 cycles; done pulses at edge N+5; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- Unsigned multiply: MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF. Response: hi=32'hFFFF_FFFE, lo=32'h0000_0001 after 5 cycles.
- Signed divide: DIV A=-7 (32'hFFFF_FFF9), B=2. Response: after 10 cycles lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- Divide corners:
  - DIVU A=100, B=0 gives lo=32'hFFFF_FFFF, hi=100.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo=32'h8000_0000, hi=0.
- Ignored requests: MTHI A=32'h1234_5678 while a DIV is in flight is ignored. After completion, MTLO A=32'hCAFE gives lo=32'hCAFE on the next edge with busy=0 and no done pulse.
- Reset mid-operation: start MULT 6*7, deassert rst_n at cycle 2. Response: hi=lo=0 and busy=0 immediately, asynchronously. No done pulse after release. A new MULT 6*7 then yields lo=42, hi=0.
